mmio_gpio: RTL and testbench
============================

MMIO_GPIO -- requirements
Module: mmio_gpio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000: base of the 16-byte register window.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a key change; legal range 1..255.
REQ-003 Port clk  input  1: single clock, all logic on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port key  input  1: raw push-button, asynchronous to clk.
REQ-006 Port addr  input  32: core data-memory byte address.
REQ-007 Port wdata  input  32: store data.
REQ-008 Port we  input  1: store strobe, one cycle per store.
REQ-009 Port re  input  1: load strobe, one cycle per load.
REQ-010 Port rdata  output  32: load data, registered.
REQ-011 Port hit  output  1: combinational; high when addr[31:4] == BASE_ADDR[31:4].
REQ-012 Port led_1  output  32: LED register 1.
REQ-013 Port led_2  output  32: LED register 2.
REQ-014 Port key_event  output  1: one-cycle pulse on an accepted key press.

Function
REQ-015 Register map (offset = addr[3:2]): 0 LED1 RW; 1 LED2 RW; 2 KEY_STATUS RO (bit0 debounced level, bit1 press flag, bits 31:2 zero); 3 KEY_CLEAR WO.
REQ-016 Store with we=1 and hit=1 SHALL update the addressed register at the next clk edge; addr[1:0] ignored; full 32-bit writes only.
REQ-017 Stores to KEY_STATUS SHALL be ignored; a store to KEY_CLEAR with wdata[1]=1 SHALL clear the press flag; KEY_CLEAR holds no state.
REQ-018 Load with re=1 and hit=1 SHALL present the register value on rdata one cycle later; KEY_CLEAR reads 0.
REQ-019 Load with hit=0, or a cycle with re=0, SHALL drive rdata to 0 on the next cycle.
REQ-020 we and re both high in one cycle: the store SHALL take effect and rdata SHALL return the pre-store value.
REQ-021 key SHALL pass through a two-flop synchronizer before any other use.
REQ-022 Debounce: 8-bit counter increments while the synchronized key differs from the debounced level and clears when they match; on reaching DEBOUNCE_CYCLES the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-023 Key-to-level latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-024 A 0->1 transition of the debounced level SHALL pulse key_event for one cycle and set the press flag in the same cycle.
REQ-025 Press flag is sticky until cleared; press set and KEY_CLEAR in the same cycle: set SHALL win.
REQ-026 A 1->0 debounced transition SHALL affect only bit0, never the flag or key_event.

Reset
REQ-027 rst_n low SHALL asynchronously force led_1=0, led_2=0, rdata=0, key_event=0, press flag=0, debounced level=0, counter=0, synchronizer flops=0.
REQ-028 Deassertion mid-press: the key SHALL be treated as a new 0->1 change and go through the full debounce.
REQ-029 Accesses presented while rst_n is low SHALL have no effect.

Structure
REQ-030 A shared package SHALL hold register-offset constants (LED1=0, LED2=1, KEY_STATUS=2, KEY_CLEAR=3), flag bit positions and the default BASE_ADDR.
REQ-031 Synchronizer, debounce counter and edge detect SHALL form one sub-module, key_debounce (ports clk, rst_n, key_raw, level, rise_pulse).
REQ-032 Total RTL 120-400 lines; no latches; one always block per register group.

Verification
REQ-033 Reset then store 32'hDEAD_BEEF to 0x1000 and 32'h0000_00FF to 0x1004 -> led_1=DEADBEEF, led_2=000000FF one edge later; loads return the same one cycle after re.
REQ-034 key high 2 cycles (DEBOUNCE_CYCLES=4) -> no key_event; KEY_STATUS at 0x1008 reads 0.
REQ-035 key held high 10 cycles -> key_event pulses exactly once, 6 cycles after the key edge; KEY_STATUS reads 3; after release it reads 2.
REQ-036 Store 2 to 0x100C in the same cycle as a new key_event -> KEY_STATUS reads 3; a later store of 2 -> reads 0.
REQ-037 Store to 0x2000 and load from 0x2000 -> hit=0, LEDs unchanged, rdata=0.
REQ-038 rst_n pulsed low for 3 cycles while led_1=DEADBEEF and the flag is set -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mmio_gpio_pkg.sv
// Shared constants for the memory-mapped GPIO block: register offsets,
// KEY_STATUS bit positions, debounce counter width and the default window base.
package mmio_gpio_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEB_CNT_W = 8;

  localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

  // Word offsets within the 16-byte window (addr[3:2])
  localparam logic [1:0] OFF_LED1       = 2'd0;
  localparam logic [1:0] OFF_LED2       = 2'd1;
  localparam logic [1:0] OFF_KEY_STATUS = 2'd2;
  localparam logic [1:0] OFF_KEY_CLEAR  = 2'd3;

  // KEY_STATUS / KEY_CLEAR bit positions
  localparam int unsigned KEY_LEVEL_BIT = 0;
  localparam int unsigned KEY_PRESS_BIT = 1;

  // Assemble the KEY_STATUS read word; all other bits read as zero
  function automatic logic [DATA_W-1:0] key_status_word(input logic level,
                                                        input logic press);
    logic [DATA_W-1:0] w;
    w                = '0;
    w[KEY_LEVEL_BIT] = level;
    w[KEY_PRESS_BIT] = press;
    return w;
  endfunction

endpackage

// File: rtl/mmio_gpio_key.sv
// Push-button conditioning: two-flop synchronizer, debounce counter and
// rising-edge strobe.
//   clk, rst_n  : clock, async active-low reset
//   key_raw     : raw asynchronous button input
//   level       : debounced key level (registered)
//   rise_pulse  : combinational strobe, high in the cycle whose closing edge
//                 moves level from 0 to 1
module key_debounce
  import mmio_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise_pulse
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 sync_1;
  logic                 sync_2;
  logic [DEB_CNT_W-1:0] cnt;
  logic                 accept;

  // Metastability guard for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= key_raw;
      sync_2 <= sync_1;
    end
  end

  // This edge is the DEBOUNCE_CYCLES-th consecutive one seeing a difference
  assign accept = (sync_2 != level) && (cnt == CNT_LAST);

  // Stability counter and debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      level <= sync_2;
    end else begin
      cnt <= cnt + DEB_CNT_W'(1);
    end
  end

  // Lets the parent update flag and event on the same edge as level
  assign rise_pulse = accept & sync_2;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: two RW LED registers, a debounced key with a sticky
// press flag, and a write-only flag-clear register in a 16-byte window.
//   clk, rst_n : clock, async active-low reset
//   key        : raw push-button input
//   addr/wdata : core byte address and store data
//   we/re      : single-cycle store / load strobes
//   rdata      : registered load data (zero when no in-window load)
//   hit        : combinational window decode
//   led_1/2    : LED registers
//   key_event  : one-cycle pulse on an accepted key press
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int unsigned       DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic [DATA_W-1:0] led_1,
  output logic [DATA_W-1:0] led_2,
  output logic              key_event
);

  logic [1:0]        offset;
  logic              addr_lsb_unused;
  logic              key_level;
  logic              key_rise;
  logic              press;
  logic              wr_led1;
  logic              wr_led2;
  logic              clr_press;
  logic [DATA_W-1:0] read_data;

  assign offset          = addr[3:2];
  assign addr_lsb_unused = ^addr[1:0];
  assign hit             = (addr[31:4] == BASE_ADDR[31:4]);

  assign wr_led1   = we && hit && (offset == OFF_LED1);
  assign wr_led2   = we && hit && (offset == OFF_LED2);
  assign clr_press = we && hit && (offset == OFF_KEY_CLEAR) && wdata[KEY_PRESS_BIT];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key),
    .level     (key_level),
    .rise_pulse(key_rise)
  );

  // LED register 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       led_1 <= '0;
    else if (wr_led1) led_1 <= wdata;
  end

  // LED register 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       led_2 <= '0;
    else if (wr_led2) led_2 <= wdata;
  end

  // Press flag and event pulse; a coincident set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press     <= 1'b0;
      key_event <= 1'b0;
    end else begin
      key_event <= key_rise;
      if (key_rise)       press <= 1'b1;
      else if (clr_press) press <= 1'b0;
    end
  end

  // Read mux over current (pre-store) register contents
  always_comb begin
    read_data = '0;
    case (offset)
      OFF_LED1:       read_data = led_1;
      OFF_LED2:       read_data = led_2;
      OFF_KEY_STATUS: read_data = key_status_word(key_level, press);
      default:        read_data = '0;
    endcase
  end

  // Load return path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdata <= '0;
    else if (re && hit) rdata <= read_data;
    else                rdata <= '0;
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register window.
module tb_mmio_gpio;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned DEB  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic [31:0] led_1;
  logic [31:0] led_2;
  logic        key_event;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned ev_count = 0;

  // Reference model state
  logic [31:0] m_led1, m_led2, m_rdata;
  logic        m_press, m_level, m_event;
  logic        m_key_q[$];   // recent key samples, oldest first
  logic        m_seen[$];    // last DEB synchronized values seen by the debouncer

  mmio_gpio #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .hit      (hit),
    .led_1    (led_1),
    .led_2    (led_2),
    .key_event(key_event)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  task automatic model_reset();
    m_led1  = '0;
    m_led2  = '0;
    m_rdata = '0;
    m_press = 1'b0;
    m_level = 1'b0;
    m_event = 1'b0;
    m_key_q = '{1'b0, 1'b0};
    m_seen  = {};
  endtask

  // One rising edge of the specified behaviour, using the inputs present before it
  task automatic model_step();
    logic [31:0] rd;
    logic        h, seen, flip, rise;
    h  = model_hit(addr);
    rd = '0;
    if (re && h) begin
      case (addr[3:2])
        2'd0:    rd = m_led1;
        2'd1:    rd = m_led2;
        2'd2:    rd = {30'd0, m_press, m_level};
        default: rd = '0;
      endcase
    end
    m_rdata = rd;

    // The debouncer sees the key as it was two edges ago
    m_key_q.push_back(key);
    seen = m_key_q[0];
    void'(m_key_q.pop_front());

    // Level follows once the last DEB seen values all disagree with it
    m_seen.push_back(seen);
    if (m_seen.size() > DEB) void'(m_seen.pop_front());
    flip = (m_seen.size() == DEB);
    foreach (m_seen[i]) if (m_seen[i] == m_level) flip = 1'b0;
    rise = flip && !m_level;
    if (flip) m_level = ~m_level;
    m_event = rise;

    if (rise) m_press = 1'b1;
    else if (we && h && addr[3:2] == 2'd3 && wdata[1]) m_press = 1'b0;

    if (we && h && addr[3:2] == 2'd0) m_led1 = wdata;
    if (we && h && addr[3:2] == 2'd1) m_led2 = wdata;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge
  task automatic cycle();
    #1;
    check("hit", 32'(hit), 32'(model_hit(addr)));
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    check("rdata", rdata, m_rdata);
    check("led_1", led_1, m_led1);
    check("led_2", led_2, m_led2);
    check("key_event", 32'(key_event), 32'(m_event));
    if (key_event) ev_count++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    cycle();
    d  = rdata;
    re = 1'b0;
  endtask

  // Counts cycles after the key edge until the first key_event, bounded
  task automatic wait_first_event(input int limit, output int first, output int count);
    int c0;
    c0    = ev_count;
    first = 0;
    for (int i = 1; i <= limit; i++) begin
      cycle();
      if (key_event && first == 0) first = i;
    end
    count = ev_count - c0;
  endtask

  initial begin
    logic [31:0] rd;
    int          first, cnt, hold;
    model_reset();

    // Reset state
    idle(2);
    check("reset led_1", led_1, 32'h0);
    check("reset led_2", led_2, 32'h0);
    check("reset rdata", rdata, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // LED stores and loads, including store+load in one cycle
    store(BASE, 32'hDEAD_BEEF);
    check("led_1 store", led_1, 32'hDEAD_BEEF);
    store(BASE + 32'h4, 32'h0000_00FF);
    check("led_2 store", led_2, 32'h0000_00FF);
    load(BASE, rd);
    check("load led1", rd, 32'hDEAD_BEEF);
    load(BASE + 32'h5, rd);
    check("load led2 low bits ignored", rd, 32'h0000_00FF);
    addr = BASE + 32'h4; wdata = 32'h1234_5678; we = 1'b1; re = 1'b1;
    cycle();
    we = 1'b0; re = 1'b0;
    check("we+re returns old", rdata, 32'h0000_00FF);
    check("we+re stores new", led_2, 32'h1234_5678);
    store(BASE + 32'h4, 32'h0000_00FF);
    load(BASE + 32'hC, rd);
    check("key_clear reads 0", rd, 32'h0);

    // Out-of-window accesses
    store(32'h0000_2000, 32'h1111_1111);
    check("miss led_1", led_1, 32'hDEAD_BEEF);
    check("miss led_2", led_2, 32'h0000_00FF);
    load(32'h0000_2000, rd);
    check("miss rdata", rd, 32'h0);
    addr = 32'h0000_2000;
    #1 check("miss hit", 32'(hit), 32'h0);

    // Short glitch is rejected
    cnt = ev_count;
    key = 1'b1;
    idle(2);
    key = 1'b0;
    idle(10);
    check("glitch events", ev_count - cnt, 0);
    load(BASE + 32'h8, rd);
    check("glitch status", rd, 32'h0);

    // Clean press: one event, 2+DEB cycles after the edge
    key = 1'b1;
    wait_first_event(10, first, cnt);
    check("press event count", cnt, 1);
    check("press latency", first, 2 + DEB);
    load(BASE + 32'h8, rd);
    check("status pressed", rd, 32'h3);
    key = 1'b0;
    idle(8);
    load(BASE + 32'h8, rd);
    check("status released", rd, 32'h2);

    // Asynchronous reset with key held; accesses during reset are ignored
    key = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async led_1", led_1, 32'h0);
    check("async led_2", led_2, 32'h0);
    check("async rdata", rdata, 32'h0);
    check("async key_event", 32'(key_event), 32'h0);
    model_reset();
    @(negedge clk);
    addr = BASE; wdata = 32'hCAFE_F00D; we = 1'b1; re = 1'b1;
    idle(3);
    we = 1'b0; re = 1'b0;
    rst_n = 1'b1;
    // Held key goes through the full debounce after reset release
    wait_first_event(12, first, cnt);
    check("post-reset event count", cnt, 1);
    check("post-reset latency", first, 2 + DEB);
    load(BASE, rd);
    check("post-reset led1", rd, 32'h0);
    key = 1'b0;
    idle(8);
    store(BASE + 32'hC, 32'h2);
    load(BASE + 32'h8, rd);
    check("cleared", rd, 32'h0);

    // Clear on the same edge as a new press: set wins
    key = 1'b1;
    idle(1 + DEB);
    store(BASE + 32'hC, 32'h2);
    check("event with clear", 32'(key_event), 32'h1);
    load(BASE + 32'h8, rd);
    check("set beats clear", rd, 32'h3);
    key = 1'b0;
    idle(8);
    store(BASE + 32'hC, 32'h1);
    load(BASE + 32'h8, rd);
    check("clear needs bit1", rd, 32'h2);
    store(BASE + 32'hC, 32'h2);
    load(BASE + 32'h8, rd);
    check("later clear", rd, 32'h0);

    // Random traffic against the model
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        key  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      case ($urandom_range(0, 5))
        0:       addr = 32'h0000_2000 + 32'($urandom_range(0, 15));
        1:       addr = $urandom;
        default: addr = BASE + 32'($urandom_range(0, 15));
      endcase
      wdata = $urandom;
      we    = ($urandom_range(0, 2) == 0);
      re    = ($urandom_range(0, 1) == 0);
      cycle();
    end
    we = 1'b0; re = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
